uart_receiver: RTL and testbench

//  Serial-to-parallel UART receiver: the receive counterpart of the UART transmit path.

---
 rtl/uart_receiver.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: synchronises rx_i, validates the start bit, samples data LSB first
// mid-bit, checks optional parity and 1/2 stop bits, and hands the byte over with valid/ack.
module uart_receiver #(
  parameter int unsigned DIV_SIZE  = 16,
  parameter int unsigned DATA_UART = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic                 stop_bits_i,
  input  logic                 parity_bit_i,
  input  logic                 parity_bit_mode_i,
  input  logic [DIV_SIZE-1:0]  baud_div_i,
  input  logic                 rx_i,
  output logic [DATA_UART-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ack_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned BcW = $clog2(DATA_UART + 1);
  localparam logic [BcW-1:0] BcLast = BcW'(DATA_UART - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // Line synchroniser and edge detector
  logic rx_meta_q, rxs_q, rx_prev_q;

  // Receive FSM state
  logic [2:0]           state_q, state_d;
  logic [DIV_SIZE-1:0]  cnt_q, cnt_d;
  logic [BcW-1:0]       bc_q, bc_d;
  logic [DATA_UART-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 busy_q, busy_d;
  logic                 deliver_q, deliver_d;

  // Per-frame configuration snapshot
  logic                 stop2_q, stop2_d;
  logic                 par_en_q, par_en_d;
  logic                 par_mode_q, par_mode_d;
  logic [DIV_SIZE-1:0]  div_q, div_d;

  // Consumer-facing registers
  logic [DATA_UART-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;

  logic fall, cnt_hit, half_hit;

  assign fall     = rx_prev_q & ~rxs_q;
  assign cnt_hit  = (cnt_q == div_q);
  assign half_hit = (cnt_q == (div_q >> 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bc_d       = bc_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_idx_d = stop_idx_q;
    busy_d     = busy_q;
    deliver_d  = 1'b0;
    stop2_d    = stop2_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    div_d      = div_q;

    unique case (state_q)
      StIdle: begin
        if (en_i && fall) begin
          stop2_d    = stop_bits_i;
          par_en_d   = parity_bit_i;
          par_mode_d = parity_bit_mode_i;
          div_d      = baud_div_i;
          cnt_d      = '0;
          bc_d       = '0;
          par_acc_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          stop_idx_d = 1'b0;
          busy_d     = 1'b1;
          // With a one-cycle bit the edge sample already is the mid-bit start sample.
          state_d    = (baud_div_i == '0) ? StData : StStart;
        end
      end

      StStart: begin
        if (half_hit) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = StData;
          end else begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + DIV_SIZE'(1);
        end
      end

      StData: begin
        if (cnt_hit) begin
          shift_d   = DATA_UART'({rxs_q, shift_q} >> 1);
          par_acc_d = par_acc_q ^ rxs_q;
          cnt_d     = '0;
          if (bc_q == BcLast) begin
            bc_d    = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bc_d = bc_q + BcW'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_SIZE'(1);
        end
      end

      StParity: begin
        if (cnt_hit) begin
          perr_d  = ((par_acc_q ^ rxs_q) != ~par_mode_q);
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + DIV_SIZE'(1);
        end
      end

      StStop: begin
        if (cnt_hit) begin
          cnt_d = '0;
          if (!rxs_q) ferr_d = 1'b1;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            deliver_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = StIdle;
          end
        end else begin
          cnt_d = cnt_q + DIV_SIZE'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Delivery has priority over ack so an ack landing on the delivery cycle keeps the new byte valid.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    if (deliver_q) begin
      data_d     = shift_q;
      perr_out_d = perr_q;
      ferr_out_d = ferr_q;
      valid_d    = 1'b1;
      ovr_d      = valid_q & ~rx_ack_i;
    end else if (rx_ack_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      rx_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bc_q       <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_idx_q <= 1'b0;
      busy_q     <= 1'b0;
      deliver_q  <= 1'b0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_mode_q <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bc_q       <= bc_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_idx_q <= stop_idx_d;
      busy_q     <= busy_d;
      deliver_q  <= deliver_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
      div_q      <= div_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed vector table, hand-written corner sequences
// and randomized frames checked against a rule-level frame model.
module tb_uart_receiver;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        en_i;
  logic        stop_bits_i;
  logic        parity_bit_i;
  logic        parity_bit_mode_i;
  logic [15:0] baud_div_i;
  logic        rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ack_i;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        busy_o;

  uart_receiver #(
    .DIV_SIZE (16),
    .DATA_UART(8)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .en_i             (en_i),
    .stop_bits_i      (stop_bits_i),
    .parity_bit_i     (parity_bit_i),
    .parity_bit_mode_i(parity_bit_mode_i),
    .baud_div_i       (baud_div_i),
    .rx_i             (rx_i),
    .rx_data_o        (rx_data_o),
    .rx_valid_o       (rx_valid_o),
    .rx_ack_i         (rx_ack_i),
    .parity_err_o     (parity_err_o),
    .frame_err_o      (frame_err_o),
    .overrun_o        (overrun_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  bit busy_seen = 1'b0;
  int ovr_cycles = 0;

  // Sample outputs 2 time units after each rising edge.
  always begin
    @(posedge clk_i);
    #2;
    if (busy_o === 1'b1) busy_seen = 1'b1;
    if (overrun_o === 1'b1) ovr_cycles++;
  end

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         pen;
    bit         pmode;
    bit         pbit;
    bit         s2;
    bit         s1_bad;
    bit         s2_bad;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drive_bit(input logic b, input int div);
    rx_i = b;
    cyc(div + 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input bit pen, input bit pmode,
                            input bit pbit, input bit s2, input bit s1_bad, input bit s2_bad,
                            input bit end_low);
    baud_div_i        = 16'(div);
    parity_bit_i      = pen;
    parity_bit_mode_i = pmode;
    stop_bits_i       = s2;
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    if (pen) drive_bit(pbit, div);
    drive_bit(~s1_bad, div);
    if (s2) drive_bit(~s2_bad, div);
    rx_i = end_low ? 1'b0 : 1'b1;
    cyc(2 * (div + 1) + 8);
  endtask

  task automatic ack_and_check(input string name);
    rx_ack_i = 1'b1;
    cyc(1);
    rx_ack_i = 1'b0;
    cyc(1);
    check({name, "_valid_cleared"}, rx_valid_o, 0);
  endtask

  task automatic check_delivery(input string name, input logic [7:0] d, input logic perr,
                                input logic ferr, input int ovr_before);
    check({name, "_valid"}, rx_valid_o, 1);
    check({name, "_data"}, rx_data_o, d);
    check({name, "_perr"}, parity_err_o, perr);
    check({name, "_ferr"}, frame_err_o, ferr);
    check({name, "_no_overrun"}, ovr_cycles, ovr_before);
    check({name, "_busy_low"}, busy_o, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"}, rx_data_o, 0);
    check({name, "_valid"}, rx_valid_o, 0);
    check({name, "_perr"}, parity_err_o, 0);
    check({name, "_ferr"}, frame_err_o, 0);
    check({name, "_ovr"}, overrun_o, 0);
    check({name, "_busy"}, busy_o, 0);
  endtask

  vec_t vecs[8];
  int   divs[6] = '{0, 1, 2, 3, 5, 15};

  initial begin
    int   ob;
    int   t;
    logic [7:0] d;
    int   div;
    bit   pen, pmode, pbit, s2, s1b, s2b;
    logic eperr, eferr;
    logic [7:0] v5a;

    vecs[0] = '{8'hA5, 15, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 15, 1, 1, 1, 0, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 15, 1, 1, 0, 0, 0, 0, 1'b1, 1'b0};
    vecs[3] = '{8'h07, 15, 1, 0, 0, 0, 0, 0, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 15, 0, 0, 0, 1, 0, 1, 1'b0, 1'b1};
    vecs[5] = '{8'h3C, 0,  0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 1,  1, 0, 1, 1, 0, 0, 1'b0, 1'b0};
    vecs[7] = '{8'hF0, 3,  0, 0, 0, 0, 1, 0, 1'b0, 1'b1};

    rstn_i            = 1'b1;
    en_i              = 1'b1;
    stop_bits_i       = 1'b0;
    parity_bit_i      = 1'b0;
    parity_bit_mode_i = 1'b0;
    baud_div_i        = 16'd15;
    rx_i              = 1'b1;
    rx_ack_i          = 1'b0;
    #2 rstn_i = 1'b0;
    #1 check_all_zero("reset");
    cyc(3);
    rstn_i = 1'b1;
    cyc(5);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      busy_seen = 1'b0;
      ob = ovr_cycles;
      send_frame(vecs[i].data, vecs[i].div, vecs[i].pen, vecs[i].pmode, vecs[i].pbit,
                 vecs[i].s2, vecs[i].s1_bad, vecs[i].s2_bad, 1'b0);
      check($sformatf("vec%0d_busy_seen", i), busy_seen, 1);
      check_delivery($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr, ob);
      ack_and_check($sformatf("vec%0d", i));
    end

    // Break: second stop bit low and the line held low afterwards
    ob = ovr_cycles;
    send_frame(8'h96, 15, 0, 0, 0, 1, 0, 1, 1'b1);
    check_delivery("break", 8'h96, 1'b0, 1'b1, ob);
    ack_and_check("break");
    busy_seen = 1'b0;
    cyc(40);
    check("break_no_restart_busy", busy_seen, 0);
    check("break_no_valid", rx_valid_o, 0);
    rx_i = 1'b1;
    cyc(20);
    send_frame(8'h3C, 15, 0, 0, 0, 0, 0, 0, 1'b0);
    check_delivery("after_break", 8'h3C, 1'b0, 1'b0, ob);
    ack_and_check("after_break");

    // Start glitch shorter than half a bit
    busy_seen = 1'b0;
    baud_div_i = 16'd15;
    stop_bits_i = 1'b0;
    parity_bit_i = 1'b0;
    rx_i = 1'b0;
    cyc(4);
    rx_i = 1'b1;
    cyc(40);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_low", busy_o, 0);
    check("glitch_no_valid", rx_valid_o, 0);

    // Receiver disabled: frame ignored entirely
    en_i = 1'b0;
    busy_seen = 1'b0;
    send_frame(8'h55, 15, 0, 0, 0, 0, 0, 0, 1'b0);
    check("disabled_no_busy", busy_seen, 0);
    check("disabled_no_valid", rx_valid_o, 0);
    en_i = 1'b1;

    // Disable mid-frame: frame still completes
    ob = ovr_cycles;
    fork
      send_frame(8'h6B, 15, 0, 0, 0, 0, 0, 0, 1'b0);
      begin
        cyc(40);
        en_i = 1'b0;
      end
    join
    check_delivery("en_drop_midframe", 8'h6B, 1'b0, 1'b0, ob);
    ack_and_check("en_drop_midframe");
    en_i = 1'b1;

    // Overrun without ack
    ob = ovr_cycles;
    send_frame(8'h11, 15, 0, 0, 0, 0, 0, 0, 1'b0);
    send_frame(8'h22, 15, 0, 0, 0, 0, 0, 0, 1'b0);
    check("overrun_one_cycle", ovr_cycles, ob + 1);
    check("overrun_valid", rx_valid_o, 1);
    check("overrun_data", rx_data_o, 8'h22);
    ack_and_check("overrun");

    // Ack landing on the delivery cycle: no overrun, valid stays set
    send_frame(8'h33, 15, 0, 0, 0, 0, 0, 0, 1'b0);
    ob = ovr_cycles;
    fork
      send_frame(8'h44, 15, 0, 0, 0, 0, 0, 0, 1'b0);
      begin
        t = 0;
        while (busy_o !== 1'b1 && t < 400) begin cyc(1); t++; end
        while (busy_o === 1'b1 && t < 400) begin cyc(1); t++; end
        check("ack_watch_in_time", (t < 400), 1);
        rx_ack_i = 1'b1;
        cyc(1);
        rx_ack_i = 1'b0;
      end
    join
    check("ack_on_delivery_no_overrun", ovr_cycles, ob);
    check("ack_on_delivery_valid", rx_valid_o, 1);
    check("ack_on_delivery_data", rx_data_o, 8'h44);

    // Asynchronous reset during data bit 3, with valid still set from the previous frame
    v5a = 8'h5A;
    baud_div_i = 16'd15;
    drive_bit(1'b0, 15);
    for (int i = 0; i < 3; i++) drive_bit(v5a[i], 15);
    rx_i = v5a[3];
    cyc(8);
    check("pre_reset_busy", busy_o, 1);
    #3 rstn_i = 1'b0;
    #1 check_all_zero("midframe_reset");
    cyc(2);
    rx_i = 1'b1;
    cyc(5);
    rstn_i = 1'b1;
    cyc(5);
    ob = ovr_cycles;
    send_frame(8'h5A, 15, 0, 0, 0, 0, 0, 0, 1'b0);
    check_delivery("after_reset", 8'h5A, 1'b0, 1'b0, ob);
    ack_and_check("after_reset");

    // Randomized frames against the frame-level model
    for (int n = 0; n < 16; n++) begin
      d     = 8'($urandom);
      div   = divs[$urandom_range(0, 5)];
      pen   = 1'($urandom);
      pmode = 1'($urandom);
      pbit  = 1'($urandom);
      s2    = 1'($urandom);
      s1b   = ($urandom_range(0, 3) == 0);
      s2b   = ($urandom_range(0, 3) == 0);
      // Even mode wants an even total of ones over data+parity, odd mode an odd total.
      eperr = pen && (pmode ? ($countones({d, pbit}) % 2 == 1) : ($countones({d, pbit}) % 2 == 0));
      eferr = s1b || (s2 && s2b);
      ob = ovr_cycles;
      send_frame(d, div, pen, pmode, pbit, s2, s1b, s2b, 1'b0);
      check_delivery($sformatf("rand%0d", n), d, eperr, eferr, ob);
      ack_and_check($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
